// File: rtl/fadd_pkg.sv
// Shared constants for the FP adder alignment stage: exponent width, FSM encoding, operand field offsets.
package fadd_pkg;

    localparam int EXP_W    = 5;
    localparam int MANT_LSB = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        SHIFT   = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Operand layout is {sign, exponent, mantissa}; offsets depend on mantissa width.
    function automatic int sign_pos(input int mant_w);
        return mant_w + EXP_W;
    endfunction

    function automatic int exp_lsb(input int mant_w);
        return mant_w;
    endfunction

endpackage

// File: rtl/fadd_align_sequencer_if.sv
// Operand-in / aligned-result-out handshake bundle for the alignment stage.
interface fadd_align_sequencer_if #(
    parameter int MANT_W = 10
);
    import fadd_pkg::*;

    localparam int SIG_W = MANT_W + 1;
    localparam int OP_W  = 1 + EXP_W + MANT_W;

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_Operand_1;
    logic [OP_W-1:0]  in_Operand_2;
    logic             out_valid;
    logic             out_ready;
    logic [EXP_W-1:0] out_Exponent;
    logic [SIG_W-1:0] out_Sig_Large;
    logic [SIG_W-1:0] out_Sig_Small;
    logic             out_Sign_Large;
    logic             out_Sign_Small;
    logic             out_Swapped;
    logic             out_Sticky;

    modport master (
        output in_valid, in_Operand_1, in_Operand_2, out_ready,
        input  in_ready, out_valid, out_Exponent, out_Sig_Large, out_Sig_Small,
               out_Sign_Large, out_Sign_Small, out_Swapped, out_Sticky
    );

    modport slave (
        input  in_valid, in_Operand_1, in_Operand_2, out_ready,
        output in_ready, out_valid, out_Exponent, out_Sig_Large, out_Sig_Small,
               out_Sign_Large, out_Sign_Small, out_Swapped, out_Sticky
    );

endinterface

// File: rtl/exp_magnitude_cmp.sv
// Combinational exponent compare: |a-b| and which operand is smaller (zero exponents rank lowest,
// with a zero second exponent never causing a swap). Latency: 0 cycles. Backpressure: none.
module exp_magnitude_cmp
    import fadd_pkg::*;
(
    input  logic [EXP_W-1:0] exp_a,
    input  logic [EXP_W-1:0] exp_b,
    output logic [EXP_W-1:0] diff,
    output logic             swap
);

    localparam logic [EXP_W-1:0] ONE = {{(EXP_W-1){1'b0}}, 1'b1};

    logic [EXP_W:0] sub;

    always_comb begin
        sub  = {1'b0, exp_a} - {1'b0, exp_b};
        // Borrow out means a<b: re-negate the two's-complement result to get the magnitude.
        diff = sub[EXP_W] ? ((~sub[EXP_W-1:0]) + ONE) : sub[EXP_W-1:0];

        if (exp_b == '0)
            swap = 1'b0;
        else if (exp_a == '0)
            swap = 1'b1;
        else
            swap = sub[EXP_W];
    end

endmodule

// File: rtl/fadd_align_sequencer.sv
// Aligns the smaller FP operand to the larger exponent, shifting one bit per cycle; latency 2 or 2+D cycles,
// one pair in flight, result held in DONE until out_ready. Sticky tracking built only with FADD_ALIGN_STICKY_EN.
module fadd_align_sequencer
    import fadd_pkg::*;
#(
    parameter int MANT_W = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    fadd_align_sequencer_if.slave  bus
);

    localparam int SIG_W    = MANT_W + 1;
    localparam int OP_W     = 1 + EXP_W + MANT_W;
    localparam int SIGN_BIT = sign_pos(MANT_W);
    localparam int EXP_LSB  = exp_lsb(MANT_W);
    localparam logic [EXP_W-1:0] ONE = {{(EXP_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [OP_W-1:0]  op1_q, op2_q;
    logic [EXP_W-1:0] exp_q;
    logic [EXP_W-1:0] count_q;
    logic [SIG_W-1:0] sig_l_q, sig_s_q;
    logic             sign_l_q, sign_s_q, swap_q;
    logic             in_rdy, out_vld;

    logic [EXP_W-1:0] e1, e2, diff;
    logic [SIG_W-1:0] sig1, sig2, sig_small_pre;
    logic             swap, big_shift;

    assign e1   = op1_q[EXP_LSB +: EXP_W];
    assign e2   = op2_q[EXP_LSB +: EXP_W];
    assign sig1 = {e1 != '0, op1_q[MANT_LSB +: MANT_W]};
    assign sig2 = {e2 != '0, op2_q[MANT_LSB +: MANT_W]};

    exp_magnitude_cmp u_cmp (
        .exp_a (e1),
        .exp_b (e2),
        .diff  (diff),
        .swap  (swap)
    );

    assign sig_small_pre = swap ? sig1 : sig2;
    // A shift wider than the significand empties it outright instead of walking through SHIFT.
    assign big_shift     = (32'(diff) > 32'(SIG_W));

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        case (state_q)
            IDLE: begin
                in_rdy = 1'b1;
                if (bus.in_valid)
                    state_d = COMPARE;
            end
            COMPARE: begin
                if (diff == '0 || big_shift)
                    state_d = DONE;
                else
                    state_d = SHIFT;
            end
            SHIFT: begin
                if (count_q == ONE)
                    state_d = DONE;
            end
            DONE: begin
                out_vld = 1'b1;
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op1_q    <= '0;
            op2_q    <= '0;
            exp_q    <= '0;
            count_q  <= '0;
            sig_l_q  <= '0;
            sig_s_q  <= '0;
            sign_l_q <= 1'b0;
            sign_s_q <= 1'b0;
            swap_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        op1_q <= bus.in_Operand_1;
                        op2_q <= bus.in_Operand_2;
                    end
                end
                COMPARE: begin
                    swap_q   <= swap;
                    exp_q    <= swap ? e2 : e1;
                    sign_l_q <= swap ? op2_q[SIGN_BIT] : op1_q[SIGN_BIT];
                    sign_s_q <= swap ? op1_q[SIGN_BIT] : op2_q[SIGN_BIT];
                    sig_l_q  <= swap ? sig2 : sig1;
                    sig_s_q  <= big_shift ? '0 : sig_small_pre;
                    count_q  <= diff;
                end
                SHIFT: begin
                    sig_s_q <= sig_s_q >> 1;
                    count_q <= count_q - ONE;
                end
                default: ;
            endcase
        end
    end

`ifdef FADD_ALIGN_STICKY_EN
    logic sticky_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE:    if (bus.in_valid) sticky_q <= 1'b0;
                COMPARE: sticky_q <= big_shift & (|sig_small_pre);
                SHIFT:   sticky_q <= sticky_q | sig_s_q[0];
                default: ;
            endcase
        end
    end

    assign bus.out_Sticky = sticky_q;
`else
    assign bus.out_Sticky = 1'b0;
`endif

    assign bus.in_ready       = in_rdy;
    assign bus.out_valid      = out_vld;
    assign bus.out_Exponent   = exp_q;
    assign bus.out_Sig_Large  = sig_l_q;
    assign bus.out_Sig_Small  = sig_s_q;
    assign bus.out_Sign_Large = sign_l_q;
    assign bus.out_Sign_Small = sign_s_q;
    assign bus.out_Swapped    = swap_q;

endmodule
